// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight, and pushes
// {pc, inst} into the instruction queue. A one-entry hold register absorbs a response
// that arrives while the queue is full. Backend redirects retarget the PC and drop
// any response still in flight.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h1ECEB000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [XLEN-1:0]   imem_addr,
  output logic [3:0]        imem_rmask,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              imem_resp,
  output logic              fifo_enqueue,
  output logic [2*XLEN-1:0] fifo_wdata,
  input  logic              fifo_is_full
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  typedef enum logic [1:0] {StReq, StWait, StDiscard, StHold} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [2*XLEN-1:0] hold_q, hold_d;
  logic [XLEN-1:0]   redirect_tgt;

  // Instructions are word aligned, so the low address bits of a redirect are dropped.
  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_addr    = pc_q;

  // State, PC and hold register update; reset restarts fetch at RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state: redirect wins over any response or push in the same cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    unique case (state_q)
      StReq: begin
        if (redirect_valid) pc_d = redirect_tgt;
        else                state_d = StWait;
      end
      StWait: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          // A response landing with the redirect is simply dropped; nothing left in flight.
          state_d = imem_resp ? StReq : StDiscard;
        end else if (imem_resp) begin
          pc_d = pc_q + PcStep;
          if (fifo_is_full) begin
            hold_d  = {pc_q, imem_rdata};
            state_d = StHold;
          end else begin
            state_d = StReq;
          end
        end
      end
      StDiscard: begin
        if (redirect_valid) pc_d = redirect_tgt;
        // The stale response retires the outstanding read even if a redirect coincides,
        // otherwise we would wait for a response that never comes.
        if (imem_resp) state_d = StReq;
      end
      StHold: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = StReq;
        end else if (!fifo_is_full) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  // Outputs: request strobe in StReq, push from the live response or the hold register.
  always_comb begin
    imem_rmask   = 4'h0;
    fifo_enqueue = 1'b0;
    fifo_wdata   = '0;
    if (!rst && !redirect_valid) begin
      unique case (state_q)
        StReq: imem_rmask = 4'hF;
        StWait: begin
          if (imem_resp && !fifo_is_full) begin
            fifo_enqueue = 1'b1;
            fifo_wdata   = {pc_q, imem_rdata};
          end
        end
        StHold: begin
          if (!fifo_is_full) begin
            fifo_enqueue = 1'b1;
            fifo_wdata   = hold_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Performance counters; free-running and untouched by redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (fifo_enqueue)                       perf_fetched_q <= perf_fetched_q + 32'd1;
      if (state_q == StHold && fifo_is_full) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  // No counters in this build; fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run scored
// against a program-order model (expected PC stream, memory as a function of address).
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h1ECEB000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        fifo_enqueue;
  logic [63:0] fifo_wdata;
  logic        fifo_is_full;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] salt;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rmask    (imem_rmask),
    .imem_rdata    (imem_rdata),
    .imem_resp     (imem_resp),
    .fifo_enqueue  (fifo_enqueue),
    .fifo_wdata    (fifo_wdata),
    .fifo_is_full  (fifo_is_full)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_rdata = '0;
    imem_resp = 1'b0; fifo_is_full = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'h0 || fifo_enqueue !== 1'b0 || fifo_wdata !== 64'h0 ||
        imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_outputs: rmask=%h enq=%b wdata=%h addr=%h, want 0 0 0 %h",
               imem_rmask, fifo_enqueue, fifo_wdata, imem_addr, RESET_PC);
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] p;
    for (int i = 0; i < 4; i++) begin
      p = RESET_PC + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (imem_rmask !== 4'hF || imem_addr !== p || fifo_enqueue !== 1'b0) begin
        errors++;
        $display("FAIL basic_req%0d: rmask=%h addr=%h enq=%b, want f %h 0",
                 i, imem_rmask, imem_addr, fifo_enqueue, p);
      end
      cyc();
      imem_resp = 1'b1; imem_rdata = mem_word(p);
      @(negedge clk);
      checks++;
      if (fifo_enqueue !== 1'b1 || fifo_wdata !== {p, mem_word(p)} || imem_rmask !== 4'h0) begin
        errors++;
        $display("FAIL basic_push%0d: enq=%b wdata=%h rmask=%h, want 1 %h 0",
                 i, fifo_enqueue, fifo_wdata, imem_rmask, {p, mem_word(p)});
      end
      cyc();
      imem_resp = 1'b0;
    end
  endtask

  task automatic test_hold;
    logic [31:0] p = RESET_PC + 32'd16;
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'hF || imem_addr !== p) begin
      errors++;
      $display("FAIL hold_req: rmask=%h addr=%h, want f %h", imem_rmask, imem_addr, p);
    end
    cyc();
    imem_resp = 1'b1; imem_rdata = mem_word(p); fifo_is_full = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_enqueue !== 1'b0) begin
      errors++;
      $display("FAIL hold_full_resp: enq=%b, want 0", fifo_enqueue);
    end
    cyc();
    imem_resp = 1'b0; imem_rdata = $urandom;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (imem_rmask !== 4'h0 || fifo_enqueue !== 1'b0) begin
        errors++;
        $display("FAIL hold_stall%0d: rmask=%h enq=%b, want 0 0", k, imem_rmask, fifo_enqueue);
      end
      cyc();
    end
    fifo_is_full = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_enqueue !== 1'b1 || fifo_wdata !== {p, mem_word(p)}) begin
      errors++;
      $display("FAIL hold_push: enq=%b wdata=%h, want 1 %h", fifo_enqueue, fifo_wdata,
               {p, mem_word(p)});
    end
    cyc();
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'hF || imem_addr !== p + 32'd4) begin
      errors++;
      $display("FAIL hold_next_req: rmask=%h addr=%h, want f %h", imem_rmask, imem_addr,
               p + 32'd4);
    end
    cyc();
    // DUT is now in WAIT for p+4; return it to a clean REQ via a plain response.
    imem_resp = 1'b1; imem_rdata = mem_word(p + 32'd4);
    cyc();
    imem_resp = 1'b0;
  endtask

  task automatic test_redirect_wait;
    logic [31:0] p = RESET_PC + 32'd24;
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'hF || imem_addr !== p) begin
      errors++;
      $display("FAIL rdw_req: rmask=%h addr=%h, want f %h", imem_rmask, imem_addr, p);
    end
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h1ECEB100;
    @(negedge clk);
    checks++;
    if (fifo_enqueue !== 1'b0 || imem_rmask !== 4'h0) begin
      errors++;
      $display("FAIL rdw_redirect: enq=%b rmask=%h, want 0 0", fifo_enqueue, imem_rmask);
    end
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'h0) begin
      errors++;
      $display("FAIL rdw_discard_idle: rmask=%h, want 0", imem_rmask);
    end
    cyc();
    imem_resp = 1'b1; imem_rdata = mem_word(p);
    @(negedge clk);
    checks++;
    if (fifo_enqueue !== 1'b0 || fifo_wdata !== 64'h0) begin
      errors++;
      $display("FAIL rdw_drop: enq=%b wdata=%h, want 0 0", fifo_enqueue, fifo_wdata);
    end
    cyc();
    imem_resp = 1'b0;
  endtask

  task automatic test_redirect_resp;
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'hF || imem_addr !== 32'h1ECEB100) begin
      errors++;
      $display("FAIL rdr_req: rmask=%h addr=%h, want f 1eceb100", imem_rmask, imem_addr);
    end
    cyc();
    imem_resp = 1'b1; imem_rdata = mem_word(32'h1ECEB100);
    redirect_valid = 1'b1; redirect_pc = 32'h1ECEB203;
    @(negedge clk);
    checks++;
    if (fifo_enqueue !== 1'b0) begin
      errors++;
      $display("FAIL rdr_no_push: enq=%b, want 0", fifo_enqueue);
    end
    cyc();
    imem_resp = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_redirect_hold;
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'hF || imem_addr !== 32'h1ECEB200) begin
      errors++;
      $display("FAIL rdh_req: rmask=%h addr=%h, want f 1eceb200", imem_rmask, imem_addr);
    end
    cyc();
    imem_resp = 1'b1; imem_rdata = mem_word(32'h1ECEB200); fifo_is_full = 1'b1;
    cyc();
    imem_resp = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1ECEB300;
    @(negedge clk);
    checks++;
    if (fifo_enqueue !== 1'b0 || imem_rmask !== 4'h0) begin
      errors++;
      $display("FAIL rdh_redirect: enq=%b rmask=%h, want 0 0", fifo_enqueue, imem_rmask);
    end
    cyc();
    redirect_valid = 1'b0; fifo_is_full = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'hF || imem_addr !== 32'h1ECEB300 || fifo_enqueue !== 1'b0) begin
      errors++;
      $display("FAIL rdh_new_req: rmask=%h addr=%h enq=%b, want f 1eceb300 0",
               imem_rmask, imem_addr, fifo_enqueue);
    end
    cyc();
    imem_resp = 1'b1; imem_rdata = mem_word(32'h1ECEB300);
    @(negedge clk);
    checks++;
    if (fifo_enqueue !== 1'b1 || fifo_wdata !== {32'h1ECEB300, mem_word(32'h1ECEB300)}) begin
      errors++;
      $display("FAIL rdh_push_target: enq=%b wdata=%h, want 1 %h", fifo_enqueue, fifo_wdata,
               {32'h1ECEB300, mem_word(32'h1ECEB300)});
    end
    cyc();
    imem_resp = 1'b0;
  endtask

  task automatic test_wrap_and_rst;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'h0) begin
      errors++;
      $display("FAIL wrap_redirect_req: rmask=%h, want 0", imem_rmask);
    end
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'hF || imem_addr !== 32'hFFFFFFFC) begin
      errors++;
      $display("FAIL wrap_req: rmask=%h addr=%h, want f fffffffc", imem_rmask, imem_addr);
    end
    cyc();
    imem_resp = 1'b1; imem_rdata = mem_word(32'hFFFFFFFC);
    @(negedge clk);
    checks++;
    if (fifo_enqueue !== 1'b1 || fifo_wdata !== {32'hFFFFFFFC, mem_word(32'hFFFFFFFC)}) begin
      errors++;
      $display("FAIL wrap_push: enq=%b wdata=%h, want 1 %h", fifo_enqueue, fifo_wdata,
               {32'hFFFFFFFC, mem_word(32'hFFFFFFFC)});
    end
    cyc();
    imem_resp = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'hF || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: rmask=%h addr=%h, want f 00000000", imem_rmask, imem_addr);
    end
    cyc();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'h0 || fifo_enqueue !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_wait: rmask=%h enq=%b, want 0 0", imem_rmask, fifo_enqueue);
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'hF || imem_addr !== RESET_PC || fifo_enqueue !== 1'b0) begin
      errors++;
      $display("FAIL rst_restart: rmask=%h addr=%h enq=%b, want f %h 0",
               imem_rmask, imem_addr, fifo_enqueue, RESET_PC);
    end
  endtask

  // Random traffic: memory with 1..3 cycle latency, random full and redirects. The model
  // only knows program order: pushes follow exp_pc, a redirect restarts it at the target.
  task automatic test_random;
    logic [31:0] exp_pc, pend_addr;
    bit          pending = 1'b0;
    int          cd = 0;
    int          pushes = 0;
    cyc();
    rst = 1'b1; redirect_valid = 1'b0; imem_resp = 1'b0; fifo_is_full = 1'b0;
    cyc();
    rst = 1'b0;
    exp_pc = RESET_PC;
    for (int i = 0; i < 3000; i++) begin
      imem_resp  = 1'b0;
      imem_rdata = $urandom;
      if (pending) begin
        if (cd == 0) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_word(pend_addr);
          pending    = 1'b0;
        end else begin
          cd--;
        end
      end
      fifo_is_full   = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      @(negedge clk);
      if (redirect_valid) begin
        checks++;
        if (fifo_enqueue !== 1'b0 || imem_rmask !== 4'h0) begin
          errors++;
          $display("FAIL rnd_redirect @%0d: enq=%b rmask=%h, want 0 0", i, fifo_enqueue,
                   imem_rmask);
        end
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        checks++;
        if (fifo_enqueue === 1'b1) begin
          if (fifo_wdata !== {exp_pc, mem_word(exp_pc)} || fifo_is_full) begin
            errors++;
            $display("FAIL rnd_push @%0d: wdata=%h full=%b, want %h 0", i, fifo_wdata,
                     fifo_is_full, {exp_pc, mem_word(exp_pc)});
          end
          exp_pc = exp_pc + 32'd4;
          pushes++;
        end else if (fifo_enqueue !== 1'b0 || fifo_wdata !== 64'h0) begin
          errors++;
          $display("FAIL rnd_idle @%0d: enq=%b wdata=%h, want 0 0", i, fifo_enqueue,
                   fifo_wdata);
        end
        checks++;
        if (imem_rmask === 4'hF) begin
          if (imem_addr !== exp_pc || pending) begin
            errors++;
            $display("FAIL rnd_req @%0d: addr=%h outstanding=%b, want %h 0", i, imem_addr,
                     pending, exp_pc);
          end
          pending   = 1'b1;
          pend_addr = imem_addr;
          cd        = $urandom_range(0, 2);
        end else if (imem_rmask !== 4'h0) begin
          errors++;
          $display("FAIL rnd_rmask @%0d: rmask=%h, want 0 or f", i, imem_rmask);
        end
      end
      cyc();
    end
    checks++;
    if (pushes < 200) begin
      errors++;
      $display("FAIL rnd_progress: pushes=%0d, want >=200", pushes);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'(pushes)) begin
      errors++;
      $display("FAIL perf_fetched: got %0d, want %0d", perf_fetched, pushes);
    end
`endif
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_basic();
    test_hold();
    test_redirect_wait();
    test_redirect_resp();
    test_redirect_hold();
    test_wrap_and_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
